// File: rtl/mmio_bus_responder_pkg.sv
// mmio_pkg: shared constants for the MMIO bus responder.
//   IO_BASE_DEFAULT    default first I/O address
//   IO_LED..IO_STAT    register offsets within the I/O window
//   sel_t              read-pipeline region select
package mmio_pkg;

  localparam logic [15:0] IO_BASE_DEFAULT = 16'hFF00;

  localparam logic [2:0] IO_LED  = 3'd0;
  localparam logic [2:0] IO_SW   = 3'd1;
  localparam logic [2:0] IO_TCNT = 3'd2;
  localparam logic [2:0] IO_TCMP = 3'd3;
  localparam logic [2:0] IO_STAT = 3'd4;

  typedef enum logic [1:0] {
    SEL_NONE = 2'd0,
    SEL_RAM  = 2'd1,
    SEL_IO   = 2'd2
  } sel_t;

endpackage

// File: rtl/mmio_bus_responder_if.sv
// mmio_bus_responder_if: CPU-side data/instruction port of the memory responder.
//   cpu_addr   CPU address, held for the whole access
//   cpu_wdata  CPU store data
//   cpu_wren   one-cycle store strobe
//   cpu_rdata  registered read data, two cycles after the address
// Modports: master (CPU side), slave (responder side).
interface mmio_bus_responder_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
);

  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              cpu_wren;
  logic [DATA_W-1:0] cpu_rdata;

  modport master (output cpu_addr, output cpu_wdata, output cpu_wren, input cpu_rdata);
  modport slave  (input cpu_addr, input cpu_wdata, input cpu_wren, output cpu_rdata);

endinterface

// File: rtl/mmio_bus_responder_sync2.sv
// mmio_sync2: two-flop synchroniser for asynchronous level inputs.
//   clk    clock
//   reset  synchronous, active-low; clears both flop stages
//   d      asynchronous input
//   q      synchronised output, two clocks behind d
module mmio_sync2 #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge clk) begin
    if (!reset) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/mmio_bus_responder.sv
// mmio_bus_responder: memory-side responder for the multicycle CPU.
// Addresses below IO_BASE go to block RAM; IO_BASE..IO_BASE+7 is a small
// register file (LED, SW, TCNT, TCMP, STAT). Reads have a fixed two-cycle
// latency. The timer and its registers exist only when MMIO_TIMER_EN is defined.
//   clk, reset   clock, synchronous active-low reset
//   cpu          CPU bus (mmio_bus_responder_if.slave)
//   ram_*        block RAM port, RAM has one-cycle read latency
//   sw_in        asynchronous switches
//   led_out      LED register
//   timer_irq    sticky timer flag
module mmio_bus_responder
  import mmio_pkg::*;
#(
  parameter int              ADDR_W   = 16,
  parameter int              DATA_W   = 16,
  parameter logic [ADDR_W-1:0] IO_BASE = ADDR_W'(IO_BASE_DEFAULT),
  parameter int              PRESCALE = 1000
) (
  input  logic              clk,
  input  logic              reset,
  mmio_bus_responder_if.slave cpu,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  output logic              ram_wren,
  input  logic [DATA_W-1:0] ram_rdata,
  input  logic [7:0]        sw_in,
  output logic [7:0]        led_out,
  output logic              timer_irq
);

  logic              in_io;
  logic              io_hit;
  logic [ADDR_W-1:0] io_rel;
  logic [2:0]        io_off;
  logic              io_wr;
  sel_t              sel_d, sel_q;
  logic [2:0]        off_q;
  logic [7:0]        led_q;
  logic [7:0]        sw_sync;
  logic [DATA_W-1:0] io_rdata;

  assign in_io  = cpu.cpu_addr >= IO_BASE;
  assign io_rel = cpu.cpu_addr - IO_BASE;
  // Only the first eight I/O addresses are decoded; the rest of the window reads 0.
  assign io_hit = in_io && (io_rel < ADDR_W'(8));
  assign io_off = io_rel[2:0];
  assign io_wr  = cpu.cpu_wren && io_hit;

  assign ram_addr  = cpu.cpu_addr;
  assign ram_wdata = cpu.cpu_wdata;
  assign ram_wren  = cpu.cpu_wren && !in_io;
  assign led_out   = led_q;

  mmio_sync2 #(.WIDTH(8)) u_sw_sync (
    .clk   (clk),
    .reset (reset),
    .d     (sw_in),
    .q     (sw_sync)
  );

  always_comb begin
    sel_d = SEL_NONE;
    if (!in_io)      sel_d = SEL_RAM;
    else if (io_hit) sel_d = SEL_IO;
  end

  // Stage 1 remembers where the read goes; stage 2 picks the data once RAM has answered.
  always_ff @(posedge clk) begin
    if (!reset) begin
      sel_q         <= SEL_NONE;
      off_q         <= '0;
      cpu.cpu_rdata <= '0;
    end else begin
      sel_q <= sel_d;
      off_q <= io_off;
      case (sel_q)
        SEL_RAM: cpu.cpu_rdata <= ram_rdata;
        SEL_IO:  cpu.cpu_rdata <= io_rdata;
        default: cpu.cpu_rdata <= '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset)                    led_q <= '0;
    else if (io_wr && io_off == IO_LED) led_q <= cpu.cpu_wdata[7:0];
  end

`ifdef MMIO_TIMER_EN
  localparam int PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  logic [PS_W-1:0]   ps_q;
  logic [DATA_W-1:0] tcnt_q, tcmp_q;
  logic              flag_q;
  logic              tick, tcmp_wr, stat_clr, flag_set;

  assign tick     = (ps_q == PS_W'(PRESCALE - 1));
  assign tcmp_wr  = io_wr && io_off == IO_TCMP;
  assign stat_clr = io_wr && io_off == IO_STAT && cpu.cpu_wdata[0];
  assign flag_set = tick && (tcmp_q != '0) && (tcnt_q == tcmp_q);
  assign timer_irq = flag_q;

  // A TCMP write restarts the whole timer so the next period is a full one.
  // A compare of zero freezes TCNT and never raises the flag.
  always_ff @(posedge clk) begin
    if (!reset) begin
      ps_q   <= '0;
      tcnt_q <= '0;
      tcmp_q <= '0;
      flag_q <= 1'b0;
    end else begin
      if (tcmp_wr) begin
        tcmp_q <= cpu.cpu_wdata;
        tcnt_q <= '0;
        ps_q   <= '0;
      end else begin
        ps_q <= tick ? '0 : ps_q + 1'b1;
        if (tick && tcmp_q != '0)
          tcnt_q <= (tcnt_q == tcmp_q) ? '0 : tcnt_q + 1'b1;
      end
      if (flag_set)      flag_q <= 1'b1;
      else if (stat_clr) flag_q <= 1'b0;
    end
  end

  always_comb begin
    io_rdata = '0;
    case (off_q)
      IO_LED:  io_rdata = DATA_W'(led_q);
      IO_SW:   io_rdata = DATA_W'(sw_sync);
      IO_TCNT: io_rdata = tcnt_q;
      IO_TCMP: io_rdata = tcmp_q;
      IO_STAT: io_rdata = DATA_W'(flag_q);
      default: io_rdata = '0;
    endcase
  end
`else
  assign timer_irq = 1'b0;

  always_comb begin
    io_rdata = '0;
    case (off_q)
      IO_LED:  io_rdata = DATA_W'(led_q);
      IO_SW:   io_rdata = DATA_W'(sw_sync);
      default: io_rdata = '0;
    endcase
  end
`endif

endmodule
